axi_lite_master_arbiter: RTL and testbench
==========================================

# axi_lite_master_arbiter

Two-requester scheduler sharing one AXI4-Lite master port. Each requester issues single read or write commands over a simple valid/ready command interface. The block arbitrates round-robin, runs the selected transaction to completion on the AXI-Lite channels with one transaction outstanding, and returns the response to the winner. It sits between the block-level register-access clients and the AXI-Lite interconnect, upstream of the existing slaves.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; WSTRB width is DATA_W/8

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester command accept, one-hot
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  write data, packed the same way
- req_wstrb  in  2*DATA_W/8  write strobes, packed the same way
- rsp_valid  out  2  one-cycle completion pulse, one-hot to the granted requester
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  captured RRESP or BRESP
- ARVALID/ARADDR/ARPROT  out  1/ADDR_W/3  read address channel
- ARREADY  in  1  read address channel
- RVALID/RDATA/RRESP  in  1/DATA_W/2  read data channel
- RREADY  out  1  read data channel
- AWVALID/AWADDR/AWPROT  out  1/ADDR_W/3  write address channel
- AWREADY  in  1  write address channel
- WVALID/WDATA/WSTRB  out  1/DATA_W/DATA_W/8  write data channel
- WREADY  in  1  write data channel
- BVALID/BRESP  in  1/2  write response channel
- BREADY  out  1  write response channel

## Operation

- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP.
- IDLE: if any req_valid is set, grant by round-robin. Priority goes to index ptr.
  - req_ready[g] is asserted combinationally for that cycle.
  - The command is captured into internal registers.
  - Next state is RD_ADDR or WR_ADDR_DATA, per req_write[g].
- RD_ADDR: ARVALID=1 with captured address, held stable until ARREADY. Then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP and go to RESP.
- WR_ADDR_DATA: AWVALID and WVALID are both asserted. Each drops independently in the cycle after its own ready is seen (aw_done/w_done flags). When both are done, go to WR_RESP. Same-cycle AWREADY and WREADY completes both at once.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to RESP.
- RESP: rsp_valid[g]=1 for one cycle. Set ptr = ~g. Go to IDLE.
- ARPROT = AWPROT = 3'b000 always.
- SLVERR/DECERR are passed through unmodified on rsp_resp; the block does not retry.
- Requesters hold their command fields stable while req_valid is high and req_ready is low.

## Timing

- Reset (rst_n=0 at an edge):
  - state=IDLE, ptr=0, done flags cleared.
  - All VALID/READY outputs, rsp_valid and req_ready are 0.
  - rsp_rdata and rsp_resp are 0.
  - An in-flight transaction is abandoned with no rsp_valid.
- All AXI outputs are registered or decoded from state. There is no combinational path from AXI inputs to AXI outputs.
- Read, minimum latency with a zero-wait slave:
  - Accept at cycle 0.
  - ARVALID at cycle 1.
  - RREADY at cycle 2, RVALID the same cycle.
  - rsp_valid at cycle 3.
- Write minimum latency matches the read (AW/W in cycle 1, BREADY in cycle 2, rsp_valid in cycle 3).
- IDLE always lasts at least one cycle between transactions. Maximum throughput is one transaction per 4 cycles.
- Simultaneous requests: ptr decides. Index ptr wins; the loser keeps req_valid and is served next.
- A single active requester is granted back-to-back regardless of ptr.
- A requester that drops req_valid before being granted is not served.

## Structure

- Shared package axi_lite_pkg holds:
  - AXI response codes: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Default PROT 3'b000.
  - The FSM state enum.
- Sub-module rr_arbiter2: inputs req[1:0] and ptr; outputs the one-hot grant. Purely combinational; ptr is updated by the parent in RESP.

## Test plan

- Read from requester 0, address 0x10. Slave gives ARREADY at once, and RVALID one cycle later with RDATA=0xCAFE0001, RRESP=00. Required: rsp_valid=2'b01 at cycle 3, rsp_rdata=0xCAFE0001, rsp_resp=00.
- Write from requester 1, address 0x20, data 0x12345678, wstrb 4'hF. Slave gives WREADY 2 cycles before AWREADY. Required:
  - WVALID drops first and AWVALID stays high until AWREADY.
  - BREADY only after both handshakes.
  - rsp_valid=2'b10, rsp_rdata=0.
- Both requesters hold req_valid continuously from reset. Required: grants alternate 0,1,0,1 over 4 transactions, one rsp_valid pulse each.
- Slave holds ARREADY low for 5 cycles. Required: ARVALID and ARADDR stay constant throughout; RREADY stays 0 until the handshake.
- Write where BRESP=2'b10. Required: rsp_resp=2'b10 delivered; next transaction proceeds normally.
- rst_n asserted in RD_DATA. Required:
  - All outputs 0 next cycle; no rsp_valid.
  - After release, requester 0 wins a simultaneous request (ptr=0).

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection and the
// master arbiter FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4,
    ST_RESP         = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: the requester at index ptr has priority, the
// other wins only when ptr's requester is idle. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between two command requesters, one
// transaction outstanding at a time, with round-robin arbitration.
module axi_lite_master_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*(DATA_W/8)-1:0] req_wstrb,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    ARVALID,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [2:0]              ARPROT,
  input  logic                    ARREADY,
  input  logic                    RVALID,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP,
  output logic                    RREADY,
  output logic                    AWVALID,
  output logic [ADDR_W-1:0]       AWADDR,
  output logic [2:0]              AWPROT,
  input  logic                    AWREADY,
  output logic                    WVALID,
  output logic [DATA_W-1:0]       WDATA,
  output logic [DATA_W/8-1:0]     WSTRB,
  input  logic                    WREADY,
  input  logic                    BVALID,
  input  logic [1:0]              BRESP,
  output logic                    BREADY
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state, state_nxt;
  logic                ptr;
  logic                gnt_idx;
  logic                aw_done, w_done;
  logic [1:0]          grant;
  logic                gnt_sel;
  logic                cmd_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign gnt_sel   = grant[1];
  assign cmd_write = gnt_sel ? req_write[1] : req_write[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A handshake counts as done if seen in an earlier cycle or on this edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt = cmd_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR:      if (ARREADY) state_nxt = ST_RD_DATA;
      ST_RD_DATA:      if (RVALID)  state_nxt = ST_RESP;
      ST_WR_ADDR_DATA: begin
        if ((aw_done || AWREADY) && (w_done || WREADY)) begin
          state_nxt = ST_WR_RESP;
        end
      end
      ST_WR_RESP:      if (BVALID)  state_nxt = ST_RESP;
      ST_RESP:         state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is masked by reset so a held request is never accepted then.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    ARVALID   = 1'b0;
    ARADDR    = '0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    AWADDR    = '0;
    WVALID    = 1'b0;
    WDATA     = '0;
    WSTRB     = '0;
    BREADY    = 1'b0;
    case (state)
      ST_IDLE:    if (rst_n) req_ready = grant;
      ST_RD_ADDR: begin
        ARVALID = 1'b1;
        ARADDR  = addr_q;
      end
      ST_RD_DATA: RREADY = 1'b1;
      ST_WR_ADDR_DATA: begin
        AWVALID = !aw_done;
        AWADDR  = aw_done ? '0 : addr_q;
        WVALID  = !w_done;
        WDATA   = w_done ? '0 : wdata_q;
        WSTRB   = w_done ? '0 : wstrb_q;
      end
      ST_WR_RESP: BREADY = 1'b1;
      ST_RESP:    rsp_valid = gnt_idx ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign ARPROT    = PROT_DEFAULT;
  assign AWPROT    = PROT_DEFAULT;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      gnt_idx <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (|req_valid) gnt_idx <= gnt_sel;
        end
        ST_WR_ADDR_DATA: begin
          if (AWREADY) aw_done <= 1'b1;
          if (WREADY)  w_done  <= 1'b1;
        end
        ST_RD_DATA: begin
          if (RVALID) begin
            rdata_q <= RDATA;
            resp_q  <= RRESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            rdata_q <= '0;
            resp_q  <= BRESP;
          end
        end
        ST_RESP: ptr <= ~gnt_idx;
        default: ;
      endcase
    end
  end

  // Command payload needs no reset: it is only observed after a capture.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && (|req_valid)) begin
      addr_q  <= gnt_sel ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
      wdata_q <= gnt_sel ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
      wstrb_q <= gnt_sel ? req_wstrb[2*STRB_W-1:STRB_W]  : req_wstrb[STRB_W-1:0];
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter with a hand-driven AXI-Lite slave.
module tb_axi_lite_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_resp;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata, ARADDR, AWADDR, WDATA, RDATA;
  logic [2:0]  ARPROT, AWPROT;
  logic [3:0]  WSTRB;
  logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY;
  logic        WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  RRESP, BRESP;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[i]       = 1'b1;
    req_write[i]       = wr;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]   = s;
  endtask

  // Entered in the cycle after acceptance; leaves the FSM in RESP.
  task automatic slave_read(input logic [31:0] exp_addr, input int ar_wait,
                            input logic [31:0] rd, input logic [1:0] rr, output int lat);
    lat = 0;
    while (!ARVALID && lat < 20) begin
      tick();
      lat++;
    end
    check("arvalid_seen", ARVALID, 1'b1);
    check("araddr", ARADDR, exp_addr);
    check("arprot", ARPROT, 3'b000);
    for (int k = 0; k < ar_wait; k++) begin
      check("arvalid_hold", ARVALID, 1'b1);
      check("araddr_hold", ARADDR, exp_addr);
      check("rready_early", RREADY, 1'b0);
      tick();
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("rready", RREADY, 1'b1);
    check("arvalid_drop", ARVALID, 1'b0);
    RVALID = 1'b1;
    RDATA  = rd;
    RRESP  = rr;
    tick();
    RVALID = 1'b0;
    RDATA  = '0;
    RRESP  = 2'b00;
  endtask

  task automatic slave_write(input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input logic [3:0] exp_strb, input int aw_wait, input int w_wait,
                             input logic [1:0] br, output int lat);
    int last;
    lat = 0;
    while (!AWVALID && lat < 20) begin
      tick();
      lat++;
    end
    check("awvalid_seen", AWVALID, 1'b1);
    check("awaddr", AWADDR, exp_addr);
    check("wdata", WDATA, exp_data);
    check("wstrb", WSTRB, exp_strb);
    check("awprot", AWPROT, 3'b000);
    last = (aw_wait > w_wait) ? aw_wait : w_wait;
    for (int k = 0; k <= last; k++) begin
      AWREADY = (k == aw_wait);
      WREADY  = (k == w_wait);
      check("awvalid_phase", AWVALID, (k <= aw_wait));
      check("wvalid_phase", WVALID, (k <= w_wait));
      check("bready_early", BREADY, 1'b0);
      tick();
    end
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    check("bready", BREADY, 1'b1);
    BVALID = 1'b1;
    BRESP  = br;
    tick();
    BVALID = 1'b0;
    BRESP  = 2'b00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_rsp_resp"}, rsp_resp, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Read from requester 0, zero-wait slave: rsp_valid in cycle 3.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    #1 check("rd0_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    slave_read(32'h10, 0, 32'hCAFE0001, 2'b00, lat);
    check("rd0_ar_latency", lat, 0);
    check("rd0_rsp_valid", rsp_valid, 2'b01);
    check("rd0_rdata", rsp_rdata, 32'hCAFE0001);
    check("rd0_resp", rsp_resp, 2'b00);
    tick();
    check("rd0_rsp_pulse", rsp_valid, 2'b00);

    // Write from requester 1, WREADY two cycles ahead of AWREADY.
    set_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    #1 check("wr1_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    slave_write(32'h20, 32'h12345678, 4'hF, 2, 0, 2'b00, lat);
    check("wr1_rsp_valid", rsp_valid, 2'b10);
    check("wr1_rdata", rsp_rdata, 32'h0);
    check("wr1_resp", rsp_resp, 2'b00);
    tick();

    // Requester 1 alone is granted even with ptr at 0; ARREADY stalls 5 cycles.
    set_req(1, 1'b0, 32'h3C, 32'h0, 4'h0);
    #1 check("rd1_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    slave_read(32'h3C, 5, 32'h0BADF00D, 2'b00, lat);
    check("rd1_rsp_valid", rsp_valid, 2'b10);
    check("rd1_rdata", rsp_rdata, 32'h0BADF00D);
    tick();

    // Write with SLVERR, then a normal read from the same requester.
    set_req(0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'h3);
    #1 check("wr0_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    slave_write(32'h40, 32'hA5A5A5A5, 4'h3, 0, 0, 2'b10, lat);
    check("wr0_rsp_valid", rsp_valid, 2'b01);
    check("wr0_slverr", rsp_resp, 2'b10);
    tick();
    set_req(0, 1'b0, 32'h44, 32'h0, 4'h0);
    #1 check("rd0b_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    slave_read(32'h44, 0, 32'h000055AA, 2'b00, lat);
    check("rd0b_rsp_valid", rsp_valid, 2'b01);
    check("rd0b_rdata", rsp_rdata, 32'h000055AA);
    check("rd0b_resp", rsp_resp, 2'b00);
    tick();

    // Reset while in RD_DATA with RVALID offered: transaction abandoned.
    set_req(1, 1'b0, 32'h80, 32'h0, 4'h0);
    #1 check("rd1b_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("rst_in_rd_data", RREADY, 1'b1);
    rst_n  = 1'b0;
    RVALID = 1'b1;
    RDATA  = 32'hDEADBEEF;
    set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h200, 32'hFEEDFACE, 4'hC);
    tick();
    RVALID = 1'b0;
    RDATA  = '0;
    check_idle_outputs("midrst");
    tick();
    check("midrst_rsp_valid2", rsp_valid, 2'b00);
    rst_n = 1'b1;

    // Both requesters held: grants alternate 0,1,0,1 starting from ptr=0.
    for (int t = 0; t < 4; t++) begin
      #1 check("alt_req_ready", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (t % 2 == 0) begin
        slave_read(32'h100, 0, 32'h1000 + t, 2'b00, lat);
        check("alt_rd_rdata", rsp_rdata, 32'h1000 + t);
      end else begin
        slave_write(32'h200, 32'hFEEDFACE, 4'hC, 0, 1, 2'b00, lat);
        check("alt_wr_rdata", rsp_rdata, 32'h0);
      end
      check("alt_rsp_valid", rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("alt_rsp_pulse", rsp_valid, 2'b00);
    end
    req_valid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
